nabp_filtered_ram_swap_control: RTL and testbench
=================================================

# nabp_filtered_ram_swap_control

Double-buffered store for filtered projection lines. It sits between the host-side angle source plus filter and the back-projection processing swappables. It fills one RAM bank with the filtered line for the current host angle while the processing side reads the other bank. Banks swap on a processing request once a full line is written.

## Interface
- ANGLE_W, 9: angle width (`kAngleLength`)
- S_W, 8: projection-line address width (`kSLength`)
- DATA_W, 16: filtered sample width (`kFilteredDataLength`)
- LINE_SIZE, 256: samples per projection line, ≤ 2^S_W
- FILTER_LATENCY, 1: cycles from `hs_s_val` to the matching `hs_val`, ≥ 0
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous reset, active-high (asserted = 1); the port keeps the codebase name
- hs_angle  in  ANGLE_W  host angle, valid while `hs_next_angle_ack`=1
- hs_has_next_angle  in  1  host has a further angle available
- hs_next_angle_ack  in  1  host accepts the request; `hs_angle` is valid
- hs_val  in  DATA_W  filter output
- pr0_s_val, pr1_s_val  in  S_W  processing read addresses
- pr_next_angle  in  1  processing requests the next line (4-phase)
- hs_s_val  out  S_W  address driven to host data source
- hs_next_angle  out  1  request next host angle; also clears the filter
- pr_angle  out  ANGLE_W  angle of the line in the processing bank
- pr_next_angle_ack  out  1  swap-done acknowledge
- pr0_val, pr1_val  out  DATA_W  processing-bank read data

## Operation
- Two banks of LINE_SIZE×DATA_W. `sel` names the processing bank; the host writes bank !sel. Contents are not reset.
- Reads are asynchronous: `prN_val = bank[sel][prN_s_val]`. An out-of-range address returns X.
- Host FSM states:
  - REQ: if `hs_has_next_angle`=0 go to DONE; else assert `hs_next_angle` and go to WAIT.
  - WAIT: hold `hs_next_angle`=1. On `hs_next_angle_ack`=1, latch `hs_angle`, drop the request, go to FILL.
  - FILL: `hs_s_val` counts 0..LINE_SIZE-1, one per cycle.
  - FLUSH: wait FILLLATENCY cycles for the filter pipeline to drain.
  - FULL: line complete; wait for a swap.
  - DONE: host is exhausted.
- Write: the address is `hs_s_val` delayed by FILTER_LATENCY, with a write enable delayed the same way. `hs_val` is written to bank !sel at that address.
- Swap, taken on the clock edge where FSM=FULL, `pr_next_angle`=1 and `pr_next_angle_ack`=0:
  - toggle `sel`;
  - `pr_angle` ← latched host angle;
  - `pr_next_angle_ack` ← 1;
  - FSM → REQ.
- Exhausted ack: if FSM=DONE, `pr_next_angle`=1 and ack=0, set `pr_next_angle_ack` ← 1 with no swap. `pr_angle` and the bank are unchanged.
- `pr_next_angle_ack` falls on the edge after `pr_next_angle` is sampled 0. No new swap is possible while ack=1.
- Outside FILL, `hs_s_val` holds 0.

## Timing
- Reset values: `hs_next_angle`=0, `hs_s_val`=0, `pr_angle`=0, `pr_next_angle_ack`=0, `sel`=0, FSM=REQ, write pipeline cleared. Reset mid-operation aborts any fill.
- Cycle after reset release: `hs_next_angle`=1 (when `hs_has_next_angle`=1).
- Ack at edge t: the first address (0) appears at t+1; the last address appears at t+LINE_SIZE. FULL is reached LINE_SIZE+FILTER_LATENCY+1 cycles after the ack edge.
- Swap: ack is visible one cycle after the qualifying edge. `pr_angle` and read data switch on the same edge.
- After a swap, `hs_next_angle` is re-asserted on the next cycle, so refill overlaps processing.
- `pr_next_angle` held high while FSM is not FULL: the request stalls with ack=0 until FULL.
- Ack and the host ack arriving in the same cycle are independent; both are honoured.

## Configuration
- `NABP_SWAP_PR1_PORT_EN`:
  - defined: `pr1_val` is a second asynchronous read port on the processing bank;
  - undefined: `pr1_s_val` is ignored and `pr1_val` is tied to 0.

## Test plan
- Reset, host with 3 angles, filter latency 1:
  - `hs_next_angle` rises one cycle after reset release;
  - `hs_s_val` sweeps 0..LINE_SIZE-1 after each host ack.
- Fill angle 0, then request with `pr_next_angle`=1 → ack rises once FULL, `pr_angle`=0, and `pr0_val[s]` equals the delayed filter value written for s, for every s.
- Hold `pr_next_angle` for 2 cycles after ack → exactly one swap; ack drops one cycle after the request drops.
- Request during FILL → ack is stalled until FULL; no partial line is exposed.
- Host exhausted (`hs_has_next_angle`=0) after the last angle A is delivered, then a further request → ack with no swap; `pr_angle`=A and data unchanged.
- Assert reset mid-FILL → all outputs return to their reset values; the next fill restarts at address 0 into bank 1.

Source files
------------

// File: rtl/nabp_filtered_ram_swap_control.sv
// Double-buffered filtered projection line store: host fills bank !sel while processing reads bank sel.
// Optional macro NABP_SWAP_PR1_PORT_EN enables the second processing read port (pr1).
module nabp_filtered_ram_swap_control #(
  parameter int ANGLE_W        = 9,
  parameter int S_W            = 8,
  parameter int DATA_W         = 16,
  parameter int LINE_SIZE      = 256,
  parameter int FILTER_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ANGLE_W-1:0] hs_angle,
  input  logic               hs_has_next_angle,
  input  logic               hs_next_angle_ack,
  input  logic [DATA_W-1:0]  hs_val,
  input  logic [S_W-1:0]     pr0_s_val,
  input  logic [S_W-1:0]     pr1_s_val,
  input  logic               pr_next_angle,
  output logic [S_W-1:0]     hs_s_val,
  output logic               hs_next_angle,
  output logic [ANGLE_W-1:0] pr_angle,
  output logic               pr_next_angle_ack,
  output logic [DATA_W-1:0]  pr0_val,
  output logic [DATA_W-1:0]  pr1_val
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FULL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int FL_CW = (FILTER_LATENCY > 1) ? $clog2(FILTER_LATENCY) : 1;
  localparam logic [S_W-1:0] S_LAST = S_W'(LINE_SIZE - 1);

  state_t             r_state;
  logic [S_W-1:0]     r_hs_s_val;
  logic               r_hs_next_angle;
  logic [ANGLE_W-1:0] r_angle;
  logic [ANGLE_W-1:0] r_pr_angle;
  logic               r_ack;
  logic               r_sel;
  logic [FL_CW-1:0]   r_flush_cnt;

  logic [DATA_W-1:0]  r_bank0 [LINE_SIZE];
  logic [DATA_W-1:0]  r_bank1 [LINE_SIZE];

  logic [S_W-1:0]     w_wr_addr;
  logic               w_wr_en;
  logic               w_filling;

  assign w_filling = (r_state == ST_FILL);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state         <= ST_REQ;
      r_hs_s_val      <= '0;
      r_hs_next_angle <= 1'b0;
      r_angle         <= '0;
      r_pr_angle      <= '0;
      r_ack           <= 1'b0;
      r_sel           <= 1'b0;
      r_flush_cnt     <= '0;
    end else begin
      // Four-phase release: ack drops once the request has been seen low.
      if (r_ack && !pr_next_angle)
        r_ack <= 1'b0;
      case (r_state)
        ST_REQ: begin
          if (!hs_has_next_angle) begin
            r_state <= ST_DONE;
          end else begin
            r_hs_next_angle <= 1'b1;
            r_state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (hs_next_angle_ack) begin
            r_angle         <= hs_angle;
            r_hs_next_angle <= 1'b0;
            r_hs_s_val      <= '0;
            r_state         <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (r_hs_s_val == S_LAST) begin
            r_hs_s_val <= '0;
            if (FILTER_LATENCY == 0) begin
              r_state <= ST_FULL;
            end else begin
              r_flush_cnt <= FL_CW'(FILTER_LATENCY - 1);
              r_state     <= ST_FLUSH;
            end
          end else begin
            r_hs_s_val <= r_hs_s_val + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0)
            r_state <= ST_FULL;
          else
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
        ST_FULL: begin
          if (pr_next_angle && !r_ack) begin
            r_sel      <= ~r_sel;
            r_pr_angle <= r_angle;
            r_ack      <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (pr_next_angle && !r_ack)
            r_ack <= 1'b1;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  // Write address/enable follow the filter pipeline so hs_val lands at its own sample index.
  generate
    if (FILTER_LATENCY == 0) begin : g_no_delay
      assign w_wr_addr = r_hs_s_val;
      assign w_wr_en   = w_filling;
    end else begin : g_delay
      logic [S_W-1:0] r_wa_pipe [FILTER_LATENCY];
      logic           r_we_pipe [FILTER_LATENCY];

      always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
          for (int i = 0; i < FILTER_LATENCY; i++) begin
            r_wa_pipe[i] <= '0;
            r_we_pipe[i] <= 1'b0;
          end
        end else begin
          r_wa_pipe[0] <= r_hs_s_val;
          r_we_pipe[0] <= w_filling;
          for (int i = 1; i < FILTER_LATENCY; i++) begin
            r_wa_pipe[i] <= r_wa_pipe[i-1];
            r_we_pipe[i] <= r_we_pipe[i-1];
          end
        end
      end

      assign w_wr_addr = r_wa_pipe[FILTER_LATENCY-1];
      assign w_wr_en   = r_we_pipe[FILTER_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (r_sel)
        r_bank0[w_wr_addr] <= hs_val;
      else
        r_bank1[w_wr_addr] <= hs_val;
    end
  end

  assign pr0_val = r_sel ? r_bank1[pr0_s_val] : r_bank0[pr0_s_val];

`ifdef NABP_SWAP_PR1_PORT_EN
  assign pr1_val = r_sel ? r_bank1[pr1_s_val] : r_bank0[pr1_s_val];
`else
  logic w_unused_pr1;
  assign w_unused_pr1 = ^pr1_s_val;
  assign pr1_val      = '0;
`endif

  assign hs_s_val          = r_hs_s_val;
  assign hs_next_angle     = r_hs_next_angle;
  assign pr_angle          = r_pr_angle;
  assign pr_next_angle_ack = r_ack;

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Bench for nabp_filtered_ram_swap_control: random angles/filter data, line contents predicted
// from a hash of (angle, sample index) produced by a one-cycle filter model.
module tb_nabp_filtered_ram_swap_control;
  localparam int ANGLE_W = 9;
  localparam int S_W     = 8;
  localparam int DATA_W  = 16;
  localparam int LS      = 256;
  localparam int FL      = 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ANGLE_W-1:0] hs_angle;
  logic               hs_has_next_angle;
  logic               hs_next_angle_ack;
  logic [DATA_W-1:0]  hs_val;
  logic [S_W-1:0]     pr0_s_val;
  logic [S_W-1:0]     pr1_s_val;
  logic               pr_next_angle;
  logic [S_W-1:0]     hs_s_val;
  logic               hs_next_angle;
  logic [ANGLE_W-1:0] pr_angle;
  logic               pr_next_angle_ack;
  logic [DATA_W-1:0]  pr0_val;
  logic [DATA_W-1:0]  pr1_val;

  always #5 clk = ~clk;

  nabp_filtered_ram_swap_control #(
    .ANGLE_W(ANGLE_W), .S_W(S_W), .DATA_W(DATA_W), .LINE_SIZE(LS), .FILTER_LATENCY(FL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hs_angle(hs_angle), .hs_has_next_angle(hs_has_next_angle),
    .hs_next_angle_ack(hs_next_angle_ack), .hs_val(hs_val), .pr0_s_val(pr0_s_val),
    .pr1_s_val(pr1_s_val), .pr_next_angle(pr_next_angle), .hs_s_val(hs_s_val),
    .hs_next_angle(hs_next_angle), .pr_angle(pr_angle), .pr_next_angle_ack(pr_next_angle_ack),
    .pr0_val(pr0_val), .pr1_val(pr1_val)
  );

  int                 n_checks = 0;
  int                 n_err    = 0;
  logic [15:0]        salt;
  logic [ANGLE_W-1:0] cur_angle;
  logic [DATA_W-1:0]  r_filt;
  logic [ANGLE_W-1:0] ang [5];

  function automatic logic [15:0] line_hash(input logic [ANGLE_W-1:0] a, input logic [S_W-1:0] s);
    logic [15:0] h;
    h = {7'd0, a} * 16'h9e37;
    h = h ^ ({8'd0, s} * 16'h01f3) ^ salt;
    return h;
  endfunction

  function automatic logic [15:0] exp_pr1(input logic [ANGLE_W-1:0] a, input logic [S_W-1:0] s);
`ifdef NABP_SWAP_PR1_PORT_EN
    return line_hash(a, s);
`else
    return 16'(s & 8'h00);
`endif
  endfunction

  // Filter model: output for the address presented one cycle earlier.
  always @(posedge clk) r_filt <= line_hash(cur_angle, hs_s_val);
  assign hs_val = r_filt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_handshake(input logic [ANGLE_W-1:0] a);
    int n = 0;
    while (hs_next_angle !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, hs_next_angle}, 32'd1);
    repeat ($urandom_range(0, 2)) begin
      step();
      chk("req_hold", {31'd0, hs_next_angle}, 32'd1);
    end
    hs_angle          = a;
    cur_angle         = a;
    hs_next_angle_ack = 1'b1;
    step();
    hs_next_angle_ack = 1'b0;
    hs_angle          = ANGLE_W'($urandom);
    chk("req_drop", {31'd0, hs_next_angle}, 32'd0);
  endtask

  // Checks the address sweep for n cycles; from req_at on, a processing request is pending and
  // must stay unacknowledged while the old line stays visible.
  task automatic sweep(input int n, input int req_at, input logic [ANGLE_W-1:0] old_a);
    logic [S_W-1:0] s;
    for (int k = 0; k < n; k++) begin
      chk("fill_addr", 32'(hs_s_val), 32'(k));
      if (k == req_at) pr_next_angle = 1'b1;
      if (req_at >= 0 && k > req_at) begin
        chk("stall_ack", {31'd0, pr_next_angle_ack}, 32'd0);
        s = S_W'($urandom);
        pr0_s_val = s;
        #1;
        chk("stall_data", 32'(pr0_val), 32'(line_hash(old_a, s)));
        chk("stall_angle", 32'(pr_angle), 32'(old_a));
      end
      step();
    end
  endtask

  task automatic wait_swap(input int e0);
    int e = e0;
    pr_next_angle = 1'b1;
    while (pr_next_angle_ack !== 1'b1 && e < e0 + 20) begin
      step();
      e++;
    end
    chk("ack_latency", 32'(e), 32'(LS + FL + 1));
  endtask

  task automatic read_line(input logic [ANGLE_W-1:0] a, input bit full);
    logic [S_W-1:0] s;
    for (int i = 0; i < (full ? LS : 16); i++) begin
      s = full ? S_W'(i) : S_W'($urandom);
      pr0_s_val = s;
      pr1_s_val = ~s;
      #1;
      chk("pr0_data", 32'(pr0_val), 32'(line_hash(a, s)));
      chk("pr1_data", 32'(pr1_val), 32'(exp_pr1(a, ~s)));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_hs_next", {31'd0, hs_next_angle}, 32'd0);
    chk("rst_s_val", 32'(hs_s_val), 32'd0);
    chk("rst_pr_angle", 32'(pr_angle), 32'd0);
    chk("rst_ack", {31'd0, pr_next_angle_ack}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    salt = 16'($urandom);
    for (int i = 0; i < 5; i++) ang[i] = ANGLE_W'(($urandom_range(1, 100) << 3) | i);
    cur_angle = '0;
    reset_n = 1'b1; hs_angle = '0; hs_has_next_angle = 1'b1; hs_next_angle_ack = 1'b0;
    pr0_s_val = '0; pr1_s_val = '0; pr_next_angle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    reset_n = 1'b0;
    step();
    chk("req_after_release", {31'd0, hs_next_angle}, 32'd1);

    // Angle 0: full fill, request after fill, held two cycles beyond ack.
    host_handshake(ang[0]);
    sweep(LS, -1, '0);
    chk("s_val_idle", 32'(hs_s_val), 32'd0);
    wait_swap(LS);
    chk("swap0_angle", 32'(pr_angle), 32'(ang[0]));
    step();
    chk("refill_req", {31'd0, hs_next_angle}, 32'd1);
    chk("ack_hold1", {31'd0, pr_next_angle_ack}, 32'd1);
    step();
    chk("ack_hold2", {31'd0, pr_next_angle_ack}, 32'd1);
    chk("one_swap_angle", 32'(pr_angle), 32'(ang[0]));
    pr_next_angle = 1'b0;
    step();
    chk("ack_drop", {31'd0, pr_next_angle_ack}, 32'd0);
    read_line(ang[0], 1'b1);

    // Angle 1: request arrives mid-fill and must stall.
    host_handshake(ang[1]);
    sweep(LS, 10, ang[0]);
    wait_swap(LS);
    chk("swap1_angle", 32'(pr_angle), 32'(ang[1]));
    pr_next_angle = 1'b0;
    step();
    chk("ack_drop1", {31'd0, pr_next_angle_ack}, 32'd0);
    read_line(ang[1], 1'b0);

    // Angle 2: last angle, then host exhausted.
    host_handshake(ang[2]);
    hs_has_next_angle = 1'b0;
    sweep(LS, -1, '0);
    wait_swap(LS);
    chk("swap2_angle", 32'(pr_angle), 32'(ang[2]));
    pr_next_angle = 1'b0;
    step();
    step();
    step();
    pr_next_angle = 1'b1;
    begin
      int n = 0;
      while (pr_next_angle_ack !== 1'b1 && n < 10) begin
        step();
        n++;
      end
    end
    chk("done_ack", {31'd0, pr_next_angle_ack}, 32'd1);
    chk("done_angle", 32'(pr_angle), 32'(ang[2]));
    chk("done_no_req", {31'd0, hs_next_angle}, 32'd0);
    read_line(ang[2], 1'b0);
    pr_next_angle = 1'b0;
    step();
    chk("done_ack_drop", {31'd0, pr_next_angle_ack}, 32'd0);

    // Reset: bank 0 (angle 1) becomes the processing bank again; then abort a fill.
    hs_has_next_angle = 1'b1;
    reset_n = 1'b1;
    #1;
    check_reset_vals();
    read_line(ang[1], 1'b0);
    reset_n = 1'b0;
    step();
    chk("req_after_release2", {31'd0, hs_next_angle}, 32'd1);
    host_handshake(ang[3]);
    sweep(20, -1, '0);
    reset_n = 1'b1;
    #1;
    check_reset_vals();
    read_line(ang[1], 1'b0);
    reset_n = 1'b0;
    step();
    host_handshake(ang[4]);
    sweep(LS, -1, '0);
    wait_swap(LS);
    chk("swap4_angle", 32'(pr_angle), 32'(ang[4]));
    pr_next_angle = 1'b0;
    step();
    read_line(ang[4], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
